// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared definitions for the node-memory arbiter. Holds the
//             memory word width, memory depth and the arbiter state encoding.
//  Contents : WORD_WIDTH, MEM_DEPTH, arb_state_t (ST_IDLE/ST_GRANT/ST_TURN),
//             idx_width() helper.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MEM_DEPTH  = 65536;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    // Width of a requester index; a single-requester build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Requester-side bundle of the memory arbiter. Each requester owns
//             one bit of req/we/gnt/rvalid and one WORD_WIDTH slice of
//             addr/wdata (requester i at [i*W +: W]); rdata is broadcast.
//  Modports : master - requester side (drives req/we/addr/wdata)
//             slave  - arbiter side   (drives gnt/rvalid/rdata)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int WORD_WIDTH = mem_arbiter_pkg::WORD_WIDTH
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            we;
    logic [N_REQ*WORD_WIDTH-1:0] addr;
    logic [N_REQ*WORD_WIDTH-1:0] wdata;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            rvalid;
    logic [WORD_WIDTH-1:0]       rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin search. Returns the first requester
//             with req set, scanning upward from ptr and wrapping at N_REQ.
//  Ports    : req (in, N_REQ)  request vector
//             ptr (in, IDX_W)  highest-priority index
//             idx (out, IDX_W) winning index (0 when none)
//             any (out, 1)     at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // One extra bit so ptr + i (< 2*N_REQ) never overflows before the wrap.
    logic [IDX_W:0] w_cand;
    logic           w_found;

    always_comb begin
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(N_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(N_REQ);
            end
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                idx     = w_cand[IDX_W-1:0];
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter sharing a single-port, one-cycle-read memory
//             between N_REQ requesters. A grant is held for a whole burst;
//             after MAX_HOLD accesses it is forced off if anyone else waits.
//  Ports    : clock, reset        clock and synchronous active-high reset
//             bus (slave)         per-requester req/we/addr/wdata, gnt/rvalid,
//                                 broadcast rdata
//             mem_address/mem_wr_en/mem_data_in  to memory
//             mem_data_out        from memory (registered read data)
//             busy                high while in GRANT or TURN
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int WORD_WIDTH = 16,
    parameter int MAX_HOLD   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_arbiter_if.slave          bus,
    output logic [WORD_WIDTH-1:0] mem_address,
    output logic                  mem_wr_en,
    output logic [WORD_WIDTH-1:0] mem_data_in,
    input  logic [WORD_WIDTH-1:0] mem_data_out,
    output logic                  busy
);

    localparam int               c_IDX_W  = idx_width(N_REQ);
    localparam int               c_HOLD_W = $clog2(MAX_HOLD);
    localparam logic [N_REQ-1:0] c_ONE    = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(N_REQ - 1);

    arb_state_t              r_state,  w_state_nx;
    logic [c_IDX_W-1:0]      r_owner,  w_owner_nx;
    logic [c_IDX_W-1:0]      r_ptr,    w_ptr_nx;
    logic [c_HOLD_W-1:0]     r_hold,   w_hold_nx;
    logic [N_REQ-1:0]        r_gnt,    w_gnt_nx;
    logic [N_REQ-1:0]        r_rvalid;
    logic [WORD_WIDTH-1:0]   r_last_addr;
    logic [WORD_WIDTH-1:0]   r_last_wdata;

    logic [WORD_WIDTH-1:0]   w_addr_arr  [N_REQ];
    logic [WORD_WIDTH-1:0]   w_wdata_arr [N_REQ];
    logic [N_REQ-1:0]        w_owner_mask;
    logic [c_IDX_W-1:0]      w_owner_succ;
    logic [c_IDX_W-1:0]      w_pick_idx;
    logic                    w_pick_any;
    logic                    w_access;
    logic                    w_others;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = bus.addr [gi*WORD_WIDTH +: WORD_WIDTH];
            assign w_wdata_arr[gi] = bus.wdata[gi*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr_pick (
        .req (bus.req),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_owner_mask = c_ONE << r_owner;
    assign w_owner_succ = (r_owner == c_IDX_LAST) ? '0 : r_owner + 1'b1;
    assign w_others     = |(bus.req & ~w_owner_mask);

    // A memory cycle belongs to the owner only while it both holds the grant
    // and still requests; the cycle in which req drops is a dead cycle.
    assign w_access = (r_state == ST_GRANT) && r_gnt[r_owner] && bus.req[r_owner];

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_ptr_nx   = r_ptr;
        w_hold_nx  = r_hold;
        w_gnt_nx   = r_gnt;
        unique case (r_state)
            ST_IDLE, ST_TURN: begin
                if (w_pick_any) begin
                    w_state_nx = ST_GRANT;
                    w_owner_nx = w_pick_idx;
                    w_gnt_nx   = c_ONE << w_pick_idx;
                    w_hold_nx  = '0;
                end else begin
                    w_state_nx = ST_IDLE;
                    w_gnt_nx   = '0;
                end
            end
            ST_GRANT: begin
                if (!bus.req[r_owner]) begin
                    w_state_nx = ST_TURN;
                    w_gnt_nx   = '0;
                    w_ptr_nx   = w_owner_succ;
                end else if (r_hold == c_HOLD_LAST) begin
                    // Saturated: only give up the bus when someone else waits.
                    if (w_others) begin
                        w_state_nx = ST_TURN;
                        w_gnt_nx   = '0;
                        w_ptr_nx   = w_owner_succ;
                    end
                end else begin
                    w_hold_nx = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_hold       <= '0;
            r_gnt        <= '0;
            r_rvalid     <= '0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_owner  <= w_owner_nx;
            r_ptr    <= w_ptr_nx;
            r_hold   <= w_hold_nx;
            r_gnt    <= w_gnt_nx;
            // Read return tracks the access, not the grant, so the final read
            // of a burst still reports even though gnt drops on the same edge.
            r_rvalid <= (w_access && !bus.we[r_owner]) ? w_owner_mask : '0;
            if (w_access) begin
                r_last_addr  <= w_addr_arr[r_owner];
                r_last_wdata <= w_wdata_arr[r_owner];
            end
        end
    end

    assign mem_address = w_access ? w_addr_arr[r_owner]  : r_last_addr;
    assign mem_data_in = w_access ? w_wdata_arr[r_owner] : r_last_wdata;
    assign mem_wr_en   = w_access && bus.we[r_owner];

    assign bus.gnt    = r_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = mem_data_out;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter (N_REQ=3, MAX_HOLD=4) with
//             a 256-word memory, a burst driver per requester, a cycle model
//             of the arbitration rules and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int NR = 3;
    localparam int W  = 16;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.N_REQ(NR), .WORD_WIDTH(W)) bus ();

    logic [W-1:0] mem_address, mem_data_in, mem_data_out;
    logic         mem_wr_en, busy;

    mem_arbiter #(.N_REQ(NR), .WORD_WIDTH(W), .MAX_HOLD(MH)) dut (
        .clock        (clk),
        .reset        (rst),
        .bus          (bus),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .busy         (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // environment memory and its copy inside the model
    logic [W-1:0] env_mem   [256];
    logic [W-1:0] model_mem [256];
    logic [W-1:0] lat_addr = '0, lat_din = '0;
    logic         lat_wr = 1'b0;

    // burst driver state
    bit           b_active [NR];
    int           b_left   [NR];
    logic [W-1:0] b_addr   [NR];
    bit           b_we     [NR];
    logic [W-1:0] b_data   [NR];
    bit           dut_acc  [NR];

    // model state
    int           m_owner = -1;
    bit           m_turn  = 0;
    int           m_ptr   = 0;
    int           m_cnt   = 0;
    logic [NR-1:0] m_rv   = '0;
    logic [W-1:0] m_rv_data = '0, m_last_addr = '0, m_last_wdata = '0;

    // traces for the directed checks
    int           acc_tr [$];
    logic [W-1:0] rv_q   [$];
    logic [NR-1:0] rvm_q [$];
    int           seg_o [$], seg_l [$], seg_g [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] addr_of(input int i);
        return bus.addr[i*W +: W];
    endfunction

    function automatic logic [W-1:0] wdata_of(input int i);
        return bus.wdata[i*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- model: applies the arbitration rules at each edge ----
    task automatic model_loop();
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = -1; m_turn = 0; m_ptr = 0; m_cnt = 0;
                m_rv = '0; m_last_addr = '0; m_last_wdata = '0;
            end else begin
                int o;
                o    = m_owner;
                m_rv = '0;
                if (o >= 0) begin
                    if (bus.req[o]) begin
                        logic [W-1:0] a, d;
                        a = addr_of(o);
                        d = wdata_of(o);
                        m_last_addr  = a;
                        m_last_wdata = d;
                        if (bus.we[o]) model_mem[a[7:0]] = d;
                        else begin
                            m_rv      = NR'(1) << o;
                            m_rv_data = model_mem[a[7:0]];
                        end
                        m_cnt++;
                        if (m_cnt >= MH && (bus.req & ~(NR'(1) << o)) != '0) begin
                            m_ptr = (o + 1) % NR; m_owner = -1; m_turn = 1;
                        end
                    end else begin
                        m_ptr = (o + 1) % NR; m_owner = -1; m_turn = 1;
                    end
                end else begin
                    m_turn = 0;
                    for (int k = 0; k < NR; k++) begin
                        int c;
                        c = (m_ptr + k) % NR;
                        if (m_owner < 0 && bus.req[c]) begin
                            m_owner = c;
                            m_cnt   = 0;
                        end
                    end
                end
            end
        end
    endtask

    // ---- compare: every cycle, away from the active edge ----
    task automatic cmp_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                bit            acc;
                logic [NR-1:0] e_gnt;
                acc   = (m_owner >= 0) && bus.req[m_owner];
                e_gnt = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
                chk("gnt", bus.gnt, e_gnt);
                chk("busy", busy, (m_owner >= 0) || m_turn);
                chk("rvalid", bus.rvalid, m_rv);
                if (m_rv != '0) chk("rdata", bus.rdata, m_rv_data);
                chk("mem_wr_en", mem_wr_en, acc && bus.we[m_owner]);
                chk("mem_address", mem_address, acc ? addr_of(m_owner) : m_last_addr);
                chk("mem_data_in", mem_data_in, acc ? wdata_of(m_owner) : m_last_wdata);
            end
            begin
                int who;
                who = -1;
                for (int i = 0; i < NR; i++) begin
                    dut_acc[i] = bus.gnt[i] && bus.req[i];
                    if (dut_acc[i]) who = i;
                end
                acc_tr.push_back(who);
            end
            if (bus.rvalid != '0) begin
                rv_q.push_back(bus.rdata);
                rvm_q.push_back(bus.rvalid);
            end
            lat_addr = mem_address;
            lat_din  = mem_data_in;
            lat_wr   = mem_wr_en;
        end
    endtask

    task automatic env_loop();
        forever begin
            @(posedge clk);
            mem_data_out <= env_mem[lat_addr[7:0]];
            if (lat_wr) env_mem[lat_addr[7:0]] <= lat_din;
        end
    endtask

    // ---- burst driver: advances address after each granted access ----
    task automatic engine_loop();
        forever begin
            logic [NR-1:0]   v_req, v_we;
            logic [NR*W-1:0] v_addr, v_data;
            @(posedge clk);
            #2;
            for (int i = 0; i < NR; i++) begin
                if (b_active[i] && dut_acc[i]) begin
                    b_left[i]--;
                    b_addr[i]++;
                    if (b_left[i] == 0) b_active[i] = 0;
                end
                v_req[i]          = b_active[i];
                v_we[i]           = b_we[i];
                v_addr[i*W +: W]  = b_addr[i];
                v_data[i*W +: W]  = b_data[i];
            end
            bus.req   = v_req;
            bus.we    = v_we;
            bus.addr  = v_addr;
            bus.wdata = v_data;
        end
    endtask

    task automatic start(input int i, input int n, input bit wr, input logic [W-1:0] a, input logic [W-1:0] d);
        b_left[i] = n; b_we[i] = wr; b_addr[i] = a; b_data[i] = d; b_active[i] = 1;
    endtask

    function automatic bit any_active();
        bit r;
        r = 0;
        for (int i = 0; i < NR; i++) r |= b_active[i];
        return r;
    endfunction

    task automatic clear_traces();
        acc_tr.delete(); rv_q.delete(); rvm_q.delete();
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int k;
        k = 0;
        tick();
        while ((any_active() || busy !== 1'b0) && k < lim) begin
            tick();
            k++;
        end
        chk({nm, "_finished_in_time"}, k < lim, 1'b1);
        tick();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) b_active[i] = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // split the access trace into (owner, length, idle gap before) segments
    task automatic analyze();
        int cur, len, gap, gb;
        bit first;
        cur = -1; len = 0; gap = 0; gb = -1; first = 1;
        seg_o.delete(); seg_l.delete(); seg_g.delete();
        foreach (acc_tr[k]) begin
            int a;
            a = acc_tr[k];
            if (a < 0) begin
                if (cur >= 0) begin
                    seg_o.push_back(cur); seg_l.push_back(len); seg_g.push_back(gb);
                end
                cur = -1;
                gap++;
            end else if (a == cur) begin
                len++;
            end else begin
                if (cur >= 0) begin
                    seg_o.push_back(cur); seg_l.push_back(len); seg_g.push_back(gb);
                end
                gb = first ? -1 : gap;
                first = 0; cur = a; len = 1; gap = 0;
            end
        end
        if (cur >= 0) begin
            seg_o.push_back(cur); seg_l.push_back(len); seg_g.push_back(gb);
        end
    endtask

    function automatic int qget(input int q [$], input int k);
        return (k < q.size()) ? q[k] : -99;
    endfunction

    function automatic logic [W-1:0] rvget(input int k);
        return (k < rv_q.size()) ? rv_q[k] : 'x;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i]   = 16'h1000 + 16'(i);
            model_mem[i] = 16'h1000 + 16'(i);
        end
        for (int i = 0; i < NR; i++) begin
            b_active[i] = 0; b_left[i] = 0; b_addr[i] = '0;
            b_we[i] = 0; b_data[i] = '0; dut_acc[i] = 0;
        end
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        fork
            model_loop();
            cmp_loop();
            env_loop();
            engine_loop();
        join_none

        tick();
        chk_en = 1;
        tick();
        chk("reset_gnt", bus.gnt, 3'b000);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        // 1: single read burst
        clear_traces();
        start(0, 3, 0, 16'd10, '0);
        @(negedge clk);
        chk("t1_gnt_same_cycle", bus.gnt, 3'b000);
        @(negedge clk);
        chk("t1_gnt_next_cycle", bus.gnt, 3'b001);
        wait_idle("t1", 50);
        analyze();
        chk("t1_segments", seg_o.size(), 1);
        chk("t1_len", qget(seg_l, 0), 3);
        chk("t1_reads", rv_q.size(), 3);
        chk("t1_rdata0", rvget(0), 16'h100A);
        chk("t1_rdata1", rvget(1), 16'h100B);
        chk("t1_rdata2", rvget(2), 16'h100C);

        // 2: write then read back
        start(1, 1, 1, 16'd100, 16'hBEEF);
        wait_idle("t2w", 50);
        clear_traces();
        start(1, 1, 0, 16'd100, '0);
        wait_idle("t2r", 50);
        chk("t2_reads", rv_q.size(), 1);
        chk("t2_rdata", rvget(0), 16'hBEEF);
        chk("t2_rvalid_mask", (rvm_q.size() > 0) ? rvm_q[0] : 3'bxxx, 3'b010);

        // 3: contention, all three together from reset
        do_reset();
        clear_traces();
        start(0, 3, 0, 16'd20, '0);
        start(1, 3, 0, 16'd40, '0);
        start(2, 3, 0, 16'd60, '0);
        wait_idle("t3", 100);
        analyze();
        chk("t3_segments", seg_o.size(), 3);
        chk("t3_owner0", qget(seg_o, 0), 0);
        chk("t3_owner1", qget(seg_o, 1), 1);
        chk("t3_owner2", qget(seg_o, 2), 2);
        chk("t3_len1", qget(seg_l, 1), 3);
        chk("t3_gap1", qget(seg_g, 1), 2);
        chk("t3_gap2", qget(seg_g, 2), 2);
        chk("t3_reads", rv_q.size(), 9);

        // 4: forced release after MAX_HOLD accesses
        do_reset();
        clear_traces();
        start(0, 10, 0, 16'd128, '0);
        start(2, 3, 0, 16'd200, '0);
        wait_idle("t4", 100);
        analyze();
        chk("t4_segments", seg_o.size(), 3);
        chk("t4_owner0", qget(seg_o, 0), 0);
        chk("t4_len0", qget(seg_l, 0), 4);
        chk("t4_owner1", qget(seg_o, 1), 2);
        chk("t4_gap1", qget(seg_g, 1), 1);
        chk("t4_owner2", qget(seg_o, 2), 0);
        chk("t4_len2", qget(seg_l, 2), 6);

        // 5: unopposed hold never released
        do_reset();
        clear_traces();
        start(1, 40, 0, 16'd0, '0);
        wait_idle("t5", 100);
        analyze();
        chk("t5_segments", seg_o.size(), 1);
        chk("t5_len", qget(seg_l, 0), 40);

        // 6: reset during a read burst
        do_reset();
        clear_traces();
        start(0, 5, 0, 16'd50, '0);
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!(bus.gnt[0] && bus.req[0]) && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk("t6_access_seen", k < 10, 1'b1);
        end
        rst = 1'b1;
        b_active[0] = 0;
        @(negedge clk);
        chk("t6_rvalid", bus.rvalid, 3'b000);
        chk("t6_gnt", bus.gnt, 3'b000);
        chk("t6_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port node memory (`mem`, 16-bit address/data, one-cycle registered read) between up to N_REQ requesters: winner policy, RNG seed fetch and reward update. It sits between those FSMs and `mem`, so each requester sees a private req/gnt port instead of muxing `address` externally. Grants are locked for bursts, with a hold limit that forces a release when others are waiting.

## Interface
- N_REQ, 3, number of requesters (2..8)
- WORD_WIDTH, 16, address and data width
- MAX_HOLD, 16, maximum consecutive granted cycles while another requester is pending (≥2)
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  N_REQ  per-requester access request; held high for a burst
- we  in  N_REQ  per-requester write enable, sampled only while granted
- addr  in  N_REQ*WORD_WIDTH  packed addresses, requester i at [i*W +: W]
- wdata  in  N_REQ*WORD_WIDTH  packed write data
- gnt  out  N_REQ  registered one-hot grant
- rvalid  out  N_REQ  registered one-hot read-data-valid
- rdata  out  WORD_WIDTH  read data, broadcast; meaningful only with rvalid
- mem_address  out  WORD_WIDTH  to mem address
- mem_wr_en  out  1  to mem write enable
- mem_data_in  out  WORD_WIDTH  to mem write data
- mem_data_out  in  WORD_WIDTH  from mem read data
- busy  out  1  high in GRANT or TURN

## Operation
- States: IDLE, GRANT, TURN. Reset → IDLE, gnt=0, rvalid=0, busy=0, ptr=0, hold=0, owner=0.
- IDLE: if any req, pick first requester with req high, searching from ptr upward with wrap; set owner and gnt[owner], hold=0, go to GRANT.
- GRANT: an access happens in a cycle only when gnt[owner] & req[owner]. mem_address=addr[owner], mem_data_in=wdata[owner], mem_wr_en=we[owner] in that cycle. Outside an access, mem_wr_en=0, and mem_address/mem_data_in hold the last value.
- GRANT exit when req[owner]=0: no access in that cycle; gnt cleared next edge; ptr=owner+1 (mod N_REQ); go to TURN.
- Forced release: hold increments per access cycle. When hold==MAX_HOLD-1 and any other req is high, that access completes, gnt clears next edge, ptr=owner+1, go to TURN. The owner must keep or re-raise req; it re-enters arbitration at lowest priority.
- When no other requester is pending, hold saturates and the grant is never forced off.
- TURN: one dead cycle, no access; arbitrate as in IDLE. Go to GRANT if any req, else IDLE.
- Read returns: an access cycle with we=0 sets rvalid[owner]=1 on the next edge, with rdata=mem_data_out. This occurs even if gnt has dropped on that edge (last read of a burst or forced release).
- Reset mid-burst: next edge forces IDLE and clears gnt/rvalid; an in-flight read is discarded, with no rvalid.

## Timing
- req rise in IDLE at edge k → gnt high after edge k+1; first access cycle is k+1..k+2.
- Read latency: address in access cycle n → rvalid/rdata valid in cycle n+1, one per read. Back-to-back reads stream one per cycle.
- Write takes effect at the end of its access cycle; no rvalid.
- Handover gap: owner drops req → one cycle with gnt still high (no access) → TURN cycle → new gnt. Minimum two idle memory cycles between owners.
- gnt is never high for two requesters; rvalid is one-hot or zero.

## Structure
- Shared package/header `mem_defs`: WORD_WIDTH, MEM_DEPTH, and state encodings ST_IDLE/ST_GRANT/ST_TURN.
- One sub-module, `rr_pick`: combinational round-robin first-one search from ptr with wrap. Inputs are req and ptr; outputs are idx and any.
- Everything else stays in mem_arbiter: FSM, hold counter, output muxes, read-return register.

## Test plan
- Single read burst: req[0]=1, we=0, addr 10,11,12, then drop → gnt[0] one cycle after req; rvalid[0] on three consecutive cycles with mem[10..12]; then TURN, then IDLE.
- Write then read: requester 1 writes 0xBEEF to 100, drops req, re-requests and reads 100 → rvalid[1] with rdata=0xBEEF.
- Contention: req[0..2] all rise together from reset → grant order 0,1,2; each burst of 3 completes; exactly 2 dead cycles between owners.
- Forced release: MAX_HOLD=4; req[0] held continuously, req[2] rises → gnt[0] drops after its 4th access; gnt[2] follows after TURN; gnt[0] returns after req[2] drops.
- Unopposed hold: req[1] alone for 40 cycles with MAX_HOLD=4 → gnt[1] never drops; 40 accesses.
- Reset mid-read: reset asserted in the cycle after a read access → no rvalid; next cycle gnt=0, busy=0, state IDLE.
